// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared FSM state encoding and byte-lane constants for dm_arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;

endpackage

// File: rtl/dm_byte_lane.sv
// rtl/dm_byte_lane.sv - byte lane extract (sign-extended) and insert for a 32-bit word
module dm_byte_lane
    import dm_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [7:0]  byte_in,
    output logic [31:0] byte_sext,
    output logic [31:0] merged
);

    logic [7:0] byte_sel;

    always_comb begin
        byte_sel = word[7:0];
        merged   = word;
        case (lane)
            LANE_B0: begin
                byte_sel     = word[7:0];
                merged[7:0]  = byte_in;
            end
            LANE_B1: begin
                byte_sel     = word[15:8];
                merged[15:8] = byte_in;
            end
            LANE_B2: begin
                byte_sel      = word[23:16];
                merged[23:16] = byte_in;
            end
            LANE_B3: begin
                byte_sel      = word[31:24];
                merged[31:24] = byte_in;
            end
            default: begin
                byte_sel = word[7:0];
                merged   = word;
            end
        endcase
    end

    assign byte_sext = {{24{byte_sel[7]}}, byte_sel};

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - CPU/DMA data-memory arbiter with byte read-modify-write
// Define DM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              byte0,
    input  logic              byte1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata0,
    output logic [31:0]       rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    state_t            state, state_nxt;
    logic              owner_q, we_q, byte_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, data_q;
    logic              sel, grant;
    logic [31:0]       byte_sext, merged, load_res;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{addr0[31:ADDR_W+2], addr1[31:ADDR_W+2]};

`ifdef DM_ARB_RR_EN
    // prio_q names the requester favoured on the next simultaneous request.
    logic prio_q;
    assign sel = (req0 && req1) ? prio_q : !req0;
`else
    assign sel = !req0;
`endif

    // Grant is gated by reset so it drops asynchronously with everything else.
    assign grant = reset && (state == ST_IDLE) && (req0 || req1);
    assign gnt0  = grant && !sel;
    assign gnt1  = grant && sel;
    assign busy  = (state != ST_IDLE);
    assign mem_addr = addr_q[ADDR_W+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
`ifdef DM_ARB_RR_EN
            prio_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= sel;
                we_q    <= sel ? we1 : we0;
                byte_q  <= sel ? byte1 : byte0;
                addr_q  <= sel ? addr1[ADDR_W+1:0] : addr0[ADDR_W+1:0];
                wdata_q <= sel ? wdata1 : wdata0;
`ifdef DM_ARB_RR_EN
                prio_q  <= !sel;
`endif
            end
            // The read word serves both loads and the byte-store merge.
            if (state == ST_ACCESS) begin
                data_q <= mem_rdata;
            end
        end
    end

    dm_byte_lane u_lane (
        .word      (data_q),
        .lane      (addr_q[1:0]),
        .byte_in   (wdata_q[7:0]),
        .byte_sext (byte_sext),
        .merged    (merged)
    );

    assign load_res = byte_q ? byte_sext : data_q;

    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        done0     = 1'b0;
        done1     = 1'b0;
        rdata0    = '0;
        rdata1    = '0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we    = we_q && !byte_q;
                state_nxt = (we_q && byte_q) ? ST_MERGE : ST_DONE;
            end
            ST_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done0 = !owner_q;
                done1 = owner_q;
                if (!we_q) begin
                    if (owner_q) begin
                        rdata1 = load_res;
                    end else begin
                        rdata0 = load_res;
                    end
                end
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter: latency/memory model plus directed literals
module tb_dm_arbiter;

`ifdef DM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, byte0 = 0, byte1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, mem_we, busy;
    logic [31:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic [31:0] tb_mem  [0:1023];
    logic [31:0] ref_mem [0:1023];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model state: one transaction in flight, counted in cycles since its grant.
    bit          m_act = 0, m_sel = 0, m_last = 1, m_we = 0, m_by = 0;
    logic [31:0] m_addr = 0, m_wd = 0;
    int          m_k = 0;

    // Event records for the directed literal checks.
    int          gnt_cyc = 0, we_cyc = 0, done_cyc = 0, we_cnt = 0;
    logic [31:0] we_addr = 0, we_data = 0, rd_last = 0, done_addr = 0;
    bit          glog[$];

    dm_arbiter #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .byte0(byte0), .byte1(byte1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle model and compare.
    always @(negedge clk) begin
        logic [5:0]  ectl;
        logic [31:0] eword, erd, ewd, b;
        int          idx, sh, len, weat;
        bit          ew, ed;
        if (!reset) begin
            chk("rst_ctl", 32'({gnt0, gnt1, done0, done1, mem_we, busy}), 32'd0);
            chk("rst_rdata0", rdata0, 32'd0);
            chk("rst_rdata1", rdata1, 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            m_act = 0;
            m_last = 1;
        end else if (!m_act) begin
            ectl = 6'd0;
            if (req0 || req1) begin
                m_sel  = (req0 && req1) ? (RR ? !m_last : 1'b0) : !req0;
                m_we   = m_sel ? we1 : we0;
                m_by   = m_sel ? byte1 : byte0;
                m_addr = m_sel ? addr1 : addr0;
                m_wd   = m_sel ? wdata1 : wdata0;
                m_last = m_sel;
                m_act  = 1;
                m_k    = 0;
                ectl   = m_sel ? 6'b010000 : 6'b100000;
            end
            chk("idle_ctl", 32'({gnt0, gnt1, done0, done1, mem_we, busy}), 32'(ectl));
            chk("idle_rdata0", rdata0, 32'd0);
            chk("idle_rdata1", rdata1, 32'd0);
        end else begin
            m_k++;
            len  = (m_we && m_by) ? 3 : 2;
            weat = m_by ? 2 : 1;
            ew   = m_we && (m_k == weat);
            ed   = (m_k == len);
            idx  = int'(m_addr[11:2]);
            sh   = 8 * int'(m_addr[1:0]);
            eword = ref_mem[idx];
            b = (eword >> sh) & 32'hFF;
            if (m_we) erd = 32'd0;
            else if (m_by) erd = (b >= 32'd128) ? (32'hFFFF_FF00 | b) : b;
            else erd = eword;
            ewd = m_by ? ((eword & ~(32'hFF << sh)) | ({24'd0, m_wd[7:0]} << sh)) : m_wd;
            ectl = {2'b00, ed && !m_sel, ed && m_sel, ew, 1'b1};
            chk("busy_ctl", 32'({gnt0, gnt1, done0, done1, mem_we, busy}), 32'(ectl));
            chk("mem_addr", 32'(mem_addr), 32'(idx));
            chk("rdata0", rdata0, (ed && !m_sel) ? erd : 32'd0);
            chk("rdata1", rdata1, (ed && m_sel) ? erd : 32'd0);
            if (ew) begin
                chk("mem_wdata", mem_wdata, ewd);
                ref_mem[idx] = ewd;
            end
            if (ed) m_act = 0;
        end
        if (gnt0 || gnt1) begin gnt_cyc = cyc; glog.push_back(gnt1); end
        if (mem_we) begin we_cyc = cyc; we_addr = 32'(mem_addr); we_data = mem_wdata; we_cnt++; end
        if (done0 || done1) begin done_cyc = cyc; rd_last = done0 ? rdata0 : rdata1; done_addr = 32'(mem_addr); end
    end

    task automatic wait_for(input int which, input string nm);
        bit ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            case (which)
                0: ok = gnt0;
                1: ok = gnt1;
                2: ok = done0;
                default: ok = done1;
            endcase
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: timeout after 20 cycles, got none expected pulse", nm);
        end
    endtask

    task automatic drive(input bit r, input bit w, input bit by, input logic [31:0] a, input logic [31:0] d);
        if (r) begin req1 = 1; we1 = w; byte1 = by; addr1 = a; wdata1 = d; end
        else   begin req0 = 1; we0 = w; byte0 = by; addr0 = a; wdata0 = d; end
    endtask

    task automatic txn(input bit r, input bit w, input bit by, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        drive(r, w, by, a, d);
        wait_for(r ? 1 : 0, "gnt");
        @(posedge clk); #1;
        if (r) req1 = 0; else req0 = 0;
        wait_for(r ? 3 : 2, "done");
        #1;
    endtask

    initial begin
        int wc;
        repeat (3) @(posedge clk);
        #1 chk("reset_busy", 32'(busy), 32'd0);
        reset = 1;

        txn(0, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wst_we_lat", 32'(we_cyc - gnt_cyc), 32'd1);
        chk("wst_done_lat", 32'(done_cyc - gnt_cyc), 32'd2);
        chk("wst_addr", we_addr, 32'd4);
        chk("wst_data", we_data, 32'hDEAD_BEEF);
        txn(0, 0, 0, 32'h0000_0010, 32'h0);
        chk("wld_rdata", rd_last, 32'hDEAD_BEEF);

        txn(1, 1, 0, 32'h0000_0010, 32'h1122_3344);
        txn(1, 1, 1, 32'h0000_0013, 32'h0000_0080);
        chk("bst_we_lat", 32'(we_cyc - gnt_cyc), 32'd2);
        chk("bst_done_lat", 32'(done_cyc - gnt_cyc), 32'd3);
        chk("bst_data", we_data, 32'h8022_3344);
        chk("bst_mem", tb_mem[4], 32'h8022_3344);
        txn(1, 0, 1, 32'h0000_0013, 32'h0);
        chk("bld_rdata", rd_last, 32'hFFFF_FF80);

        txn(0, 1, 0, 32'h0000_0006, 32'h0102_0304);
        chk("w6_addr", we_addr, 32'd1);
        chk("w6_mem", tb_mem[1], 32'h0102_0304);
        txn(1, 0, 0, 32'hFFFF_F004, 32'h0);
        chk("hi_addr", done_addr, 32'd1);
        chk("hi_rdata", rd_last, 32'h0102_0304);

        // A store request raised and dropped while busy must leave no trace.
        wc = we_cnt;
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0000_0010, 32'h0);
        wait_for(0, "gnt_spur");
        @(posedge clk); #1;
        req0 = 0;
        drive(1, 1, 0, 32'h0000_0010, 32'h0000_0BAD);
        @(posedge clk); #1;
        req1 = 0;
        wait_for(2, "done_spur");
        repeat (2) @(posedge clk);
        #1 chk("spur_we_cnt", 32'(we_cnt - wc), 32'd0);
        chk("spur_mem", tb_mem[4], 32'h8022_3344);

        // Reset while the byte-store merge write is pending.
        txn(0, 1, 0, 32'h0000_0020, 32'hA5A5_A5A5);
        wc = we_cnt;
        @(posedge clk); #1;
        drive(0, 1, 1, 32'h0000_0021, 32'h0000_0055);
        wait_for(0, "gnt_rst");
        @(posedge clk); #1;
        req0 = 0;
        @(posedge clk); #2;
        reset = 0;
        #1 chk("async_ctl", 32'({gnt0, gnt1, done0, done1, mem_we, busy}), 32'd0);
        chk("async_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        chk("rst_mem_kept", tb_mem[8], 32'hA5A5_A5A5);
        chk("rst_we_cnt", 32'(we_cnt - wc), 32'd0);

        // Simultaneous requests held through four transactions.
        glog.delete();
        @(posedge clk); #1;
        drive(0, 0, 0, 32'h0000_0010, 32'h0);
        drive(1, 0, 0, 32'h0000_0004, 32'h0);
        repeat (12) @(posedge clk);
        #1 req0 = 0;
        wait_for(1, "gnt1_after_drop");
        @(posedge clk); #1;
        req1 = 0;
        wait_for(3, "done1_after_drop");
        #1;
        chk("arb_count", 32'(glog.size()), 32'd5);
        for (int i = 0; i < 4; i++) begin
            bit e;
            e = RR ? bit'(i % 2) : 1'b0;
            if (i < glog.size()) chk($sformatf("arb_seq%0d", i), 32'(glog[i]), 32'(e));
        end
        if (glog.size() > 4) chk("arb_seq4", 32'(glog[4]), 32'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
